// File: rtl/stream_mux_arb.sv
// N_IN:1 valid/ready stream multiplexer with fixed-priority or round-robin arbitration and a registered output stage.
// Optional packet lock enabled by defining STREAM_MUX_ARB_LOCK_EN (adds in_last/out_last).
module stream_mux_arb #(
  parameter int  WIDTH = 32,
  parameter int  N_IN  = 4,
  parameter int  MODE  = 1,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_IN-1:0]         in_valid,
  input  logic [N_IN*WIDTH-1:0]   in_data,
  output logic [N_IN-1:0]         in_ready,
`ifdef STREAM_MUX_ARB_LOCK_EN
  input  logic [N_IN-1:0]         in_last,
  output logic                    out_last,
`endif
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [SEL_W-1:0] ptr_r;

  logic             load_s;
  logic             xfer_s;
  logic [N_IN-1:0]  grant_s;
  logic [SEL_W-1:0] win_idx_s;
  logic [WIDTH-1:0] win_data_s;
  logic             last_s;
  logic             lock_hold_s;
  logic [SEL_W-1:0] lock_ch_s;

`ifdef STREAM_MUX_ARB_LOCK_EN
  logic             locked_r;
  logic [SEL_W-1:0] lock_ch_r;
  logic             out_last_r;

  assign lock_hold_s = locked_r;
  assign lock_ch_s   = lock_ch_r;
  assign last_s      = |(grant_s & in_last);
  assign out_last    = out_last_r;
`else
  // Without packet lock every beat counts as the last one of its packet.
  assign lock_hold_s = 1'b0;
  assign lock_ch_s   = {SEL_W{1'b0}};
  assign last_s      = 1'b1;
`endif

  // Output stage can take a new beat when empty or being drained; nothing is offered while in reset.
  always_comb begin
    load_s = rst_n & (~out_valid_r | out_ready);
  end

  // One-hot grant: locked channel, or first valid channel searching from the pointer (MODE 1) or from 0 (MODE 0).
  always_comb begin
    logic [SEL_W-1:0] idx_v;
    logic             found_v;
    logic             take_v;
    grant_s   = {N_IN{1'b0}};
    win_idx_s = {SEL_W{1'b0}};
    idx_v     = {SEL_W{1'b0}};
    found_v   = 1'b0;
    take_v    = 1'b0;
    if (lock_hold_s) begin
      grant_s[lock_ch_s] = in_valid[lock_ch_s];
      win_idx_s          = lock_ch_s;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        idx_v          = (MODE == 1) ? SEL_W'((int'(ptr_r) + k) % N_IN) : SEL_W'(k);
        take_v         = ~found_v & in_valid[idx_v];
        grant_s[idx_v] = grant_s[idx_v] | take_v;
        win_idx_s      = take_v ? idx_v : win_idx_s;
        found_v        = found_v | take_v;
      end
    end
  end

  // AND-OR payload mux driven by the one-hot grant.
  always_comb begin
    win_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_IN; i++) begin
      win_data_s = win_data_s | ({WIDTH{grant_s[i]}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

  assign xfer_s   = load_s & (|grant_s);
  assign in_ready = grant_s & {N_IN{load_s}};

  // Output register: capture on transfer, drop valid when loading with nothing offered, hold under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= {SEL_W{1'b0}};
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= win_data_s;
      out_sel_r   <= win_idx_s;
    end else if (load_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner, only on the closing beat of a packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= {SEL_W{1'b0}};
    end else if ((MODE == 1) && xfer_s && last_s) begin
      ptr_r <= (win_idx_s == SEL_W'(N_IN - 1)) ? {SEL_W{1'b0}} : (win_idx_s + SEL_W'(1));
    end
  end

`ifdef STREAM_MUX_ARB_LOCK_EN
  // Lock holds the grant on a channel from its first non-last beat until its last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_r   <= 1'b0;
      lock_ch_r  <= {SEL_W{1'b0}};
      out_last_r <= 1'b0;
    end else if (xfer_s) begin
      locked_r   <= ~last_s;
      lock_ch_r  <= win_idx_s;
      out_last_r <= last_s;
    end
  end
`endif

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sel   = out_sel_r;

endmodule
